// File: rtl/multicycle_control_unit_if.sv
// Control and memory-port bundle between multicycle_control_unit (master) and the
// datapath/memory side (slave); mem_error exists only when MEM_TIMEOUT_EN is defined.
interface multicycle_control_unit_if #(
   parameter int WORD_SIZE = 16,
   parameter int CNT_WIDTH = 16
);
   logic [WORD_SIZE-1:0] instruction;
   logic                 mem_ready;
   logic                 branch_taken;

   logic                 mem_read;
   logic                 mem_write;
   logic                 i_or_d;
   logic                 ir_write;
   logic                 pc_write;
   logic [1:0]           pc_src;
   logic                 reg_write;
   logic [1:0]           reg_dst;
   logic [1:0]           wb_sel;
   logic                 alu_src;
   logic [3:0]           alu_op;
   logic                 output_en;
   logic                 is_halted;
   logic [CNT_WIDTH-1:0] num_inst;
`ifdef MEM_TIMEOUT_EN
   logic                 mem_error;
`endif

`ifdef MEM_TIMEOUT_EN
   modport master (
      input  instruction, mem_ready, branch_taken,
      output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
             reg_write, reg_dst, wb_sel, alu_src, alu_op, output_en,
             is_halted, num_inst, mem_error
   );
   modport slave (
      output instruction, mem_ready, branch_taken,
      input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
             reg_write, reg_dst, wb_sel, alu_src, alu_op, output_en,
             is_halted, num_inst, mem_error
   );
`else
   modport master (
      input  instruction, mem_ready, branch_taken,
      output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
             reg_write, reg_dst, wb_sel, alu_src, alu_op, output_en,
             is_halted, num_inst
   );
   modport slave (
      output instruction, mem_ready, branch_taken,
      input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
             reg_write, reg_dst, wb_sel, alu_src, alu_op, output_en,
             is_halted, num_inst
   );
`endif
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM for the 16-bit ISA with memory-ready stalls and
// a retire counter. Optional MEM_TIMEOUT_EN adds a per-access wait limit and sticky mem_error.
module multicycle_control_unit #(
   parameter int WORD_SIZE   = 16,
   parameter int CNT_WIDTH   = 16,
   parameter int MEM_TIMEOUT = 255
) (
   input logic                       clk,
   input logic                       reset,
   multicycle_control_unit_if.master bus
);

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

   typedef enum logic [3:0] {
      C_RALU, C_IALU, C_LWD, C_SWD, C_BRANCH, C_JMP,
      C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_UNDEF
   } iclass_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] wb_sel;
      logic       alu_src;
      logic [3:0] alu_op;
      logic       output_en;
   } ctrl_t;

   localparam logic [3:0] OP_BNE = 4'd0,  OP_BEQ = 4'd1,  OP_BGZ = 4'd2,  OP_BLZ = 4'd3;
   localparam logic [3:0] OP_ADI = 4'd4,  OP_ORI = 4'd5,  OP_LHI = 4'd6,  OP_LWD = 4'd7;
   localparam logic [3:0] OP_SWD = 4'd8,  OP_JMP = 4'd9,  OP_JAL = 4'd10, OP_RTYPE = 4'd15;

   localparam logic [5:0] FN_ADD = 6'd0,  FN_SUB = 6'd1,  FN_AND = 6'd2,  FN_ORR = 6'd3;
   localparam logic [5:0] FN_NOT = 6'd4,  FN_TCP = 6'd5,  FN_SHL = 6'd6,  FN_SHR = 6'd7;
   localparam logic [5:0] FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;

   localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h5, ALU_ORR = 4'h6;
   localparam logic [3:0] ALU_NOT = 4'h9, ALU_SHR = 4'hA, ALU_TCP = 4'hC, ALU_SHL = 4'hD;
   localparam logic [3:0] ALU_LHI = 4'hF;

   logic [3:0]           opcode;
   logic [5:0]           func;
   iclass_t              iclass;
   logic [3:0]           dec_alu_op;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   ctrl_t                ctrl;
   logic                 retire;
   logic                 wait_stall;
   logic                 timeout_hit;
   logic                 unused_bits;

   assign opcode      = bus.instruction[WORD_SIZE-1 -: 4];
   assign func        = bus.instruction[5:0];
   assign unused_bits = ^bus.instruction[WORD_SIZE-5:6];

   always_comb begin
      iclass     = C_UNDEF;
      dec_alu_op = ALU_ADD;
      case (opcode)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
            iclass     = C_BRANCH;
            dec_alu_op = ALU_SUB;
         end
         OP_ADI: iclass = C_IALU;
         OP_ORI: begin
            iclass     = C_IALU;
            dec_alu_op = ALU_ORR;
         end
         OP_LHI: begin
            iclass     = C_IALU;
            dec_alu_op = ALU_LHI;
         end
         OP_LWD: iclass = C_LWD;
         OP_SWD: iclass = C_SWD;
         OP_JMP: iclass = C_JMP;
         OP_JAL: iclass = C_JAL;
         OP_RTYPE: begin
            case (func)
               FN_ADD: begin iclass = C_RALU; dec_alu_op = ALU_ADD; end
               FN_SUB: begin iclass = C_RALU; dec_alu_op = ALU_SUB; end
               FN_AND: begin iclass = C_RALU; dec_alu_op = ALU_AND; end
               FN_ORR: begin iclass = C_RALU; dec_alu_op = ALU_ORR; end
               FN_NOT: begin iclass = C_RALU; dec_alu_op = ALU_NOT; end
               FN_TCP: begin iclass = C_RALU; dec_alu_op = ALU_TCP; end
               FN_SHL: begin iclass = C_RALU; dec_alu_op = ALU_SHL; end
               FN_SHR: begin iclass = C_RALU; dec_alu_op = ALU_SHR; end
               FN_JPR: iclass = C_JPR;
               FN_JRL: iclass = C_JRL;
               FN_WWD: iclass = C_WWD;
               FN_HLT: iclass = C_HLT;
               default: iclass = C_UNDEF;
            endcase
         end
         default: iclass = C_UNDEF;
      endcase
   end

   assign wait_stall = ((state_q == S_IF) || (state_q == S_MEM)) && !bus.mem_ready;

`ifdef MEM_TIMEOUT_EN
   localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_error_q, mem_error_d;

   // Any cycle that is not a stall clears the counter, so each IF/MEM visit starts from zero.
   assign timeout_hit = (int'(wait_q) + 1 >= MEM_TIMEOUT);

   always_comb begin
      wait_d      = wait_stall ? wait_q + 1'b1 : '0;
      mem_error_d = mem_error_q | (wait_stall && timeout_hit);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q      <= '0;
         mem_error_q <= 1'b0;
      end else begin
         wait_q      <= wait_d;
         mem_error_q <= mem_error_d;
      end
   end

   assign bus.mem_error = mem_error_q && !reset;
`else
   logic unused_cfg;

   assign timeout_hit = 1'b0;
   assign unused_cfg  = ^MEM_TIMEOUT;
`endif

   // NOTE: every value written here gets a default first, so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      retire  = 1'b0;
      if (!reset) begin
         case (state_q)
            S_IF: begin
               ctrl.mem_read = 1'b1;
               if (bus.mem_ready) begin
                  ctrl.ir_write = 1'b1;
                  ctrl.pc_write = 1'b1;
                  ctrl.pc_src   = 2'b00;
                  state_d       = S_ID;
               end else if (timeout_hit) begin
                  state_d = S_HALT;
               end
            end
            S_ID: begin
               case (iclass)
                  C_RALU, C_IALU, C_LWD, C_SWD, C_BRANCH: state_d = S_EX;
                  C_JMP, C_JAL: begin
                     ctrl.pc_write  = 1'b1;
                     ctrl.pc_src    = 2'b10;
                     ctrl.reg_write = (iclass == C_JAL);
                     ctrl.reg_dst   = (iclass == C_JAL) ? 2'b10 : 2'b00;
                     ctrl.wb_sel    = (iclass == C_JAL) ? 2'b10 : 2'b00;
                     retire         = 1'b1;
                     state_d        = S_IF;
                  end
                  C_JPR, C_JRL: begin
                     ctrl.pc_write  = 1'b1;
                     ctrl.pc_src    = 2'b11;
                     ctrl.reg_write = (iclass == C_JRL);
                     ctrl.reg_dst   = (iclass == C_JRL) ? 2'b10 : 2'b00;
                     ctrl.wb_sel    = (iclass == C_JRL) ? 2'b10 : 2'b00;
                     retire         = 1'b1;
                     state_d        = S_IF;
                  end
                  C_WWD: begin
                     ctrl.output_en = 1'b1;
                     retire         = 1'b1;
                     state_d        = S_IF;
                  end
                  C_HLT: begin
                     retire  = 1'b1;
                     state_d = S_HALT;
                  end
                  default: begin
                     retire  = 1'b1;
                     state_d = S_IF;
                  end
               endcase
            end
            S_EX: begin
               ctrl.alu_op = dec_alu_op;
               case (iclass)
                  C_RALU: state_d = S_WB;
                  C_IALU: begin
                     ctrl.alu_src = 1'b1;
                     state_d      = S_WB;
                  end
                  C_LWD, C_SWD: begin
                     ctrl.alu_src = 1'b1;
                     state_d      = S_MEM;
                  end
                  C_BRANCH: begin
                     ctrl.pc_write = bus.branch_taken;
                     ctrl.pc_src   = 2'b01;
                     retire        = 1'b1;
                     state_d       = S_IF;
                  end
                  default: state_d = S_IF;
               endcase
            end
            S_MEM: begin
               ctrl.i_or_d    = 1'b1;
               ctrl.mem_write = (iclass == C_SWD);
               ctrl.mem_read  = (iclass != C_SWD);
               if (bus.mem_ready) begin
                  if (iclass == C_SWD) begin
                     retire  = 1'b1;
                     state_d = S_IF;
                  end else begin
                     state_d = S_WB;
                  end
               end else if (timeout_hit) begin
                  state_d = S_HALT;
               end
            end
            S_WB: begin
               ctrl.reg_write = 1'b1;
               ctrl.reg_dst   = (iclass == C_RALU) ? 2'b01 : 2'b00;
               ctrl.wb_sel    = (iclass == C_LWD) ? 2'b01 : 2'b00;
               retire         = 1'b1;
               state_d        = S_IF;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
         endcase
      end
      cnt_d = cnt_q + CNT_WIDTH'(retire);
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.mem_read  = ctrl.mem_read;
   assign bus.mem_write = ctrl.mem_write;
   assign bus.i_or_d    = ctrl.i_or_d;
   assign bus.ir_write  = ctrl.ir_write;
   assign bus.pc_write  = ctrl.pc_write;
   assign bus.pc_src    = ctrl.pc_src;
   assign bus.reg_write = ctrl.reg_write;
   assign bus.reg_dst   = ctrl.reg_dst;
   assign bus.wb_sel    = ctrl.wb_sel;
   assign bus.alu_src   = ctrl.alu_src;
   assign bus.alu_op    = ctrl.alu_op;
   assign bus.output_en = ctrl.output_en;
   assign bus.is_halted = (state_q == S_HALT) && !reset;
   assign bus.num_inst  = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit: a per-instruction-class
// schedule model predicts every cycle's control outputs, halt flag and retire count.
module tb_multicycle_control_unit;

   localparam int WS  = 16;
   localparam int CW  = 4;
   localparam int TMO = 4;

   typedef enum {K_RALU, K_IALU, K_LWD, K_SWD, K_BR, K_JMP, K_JAL, K_JPR, K_JRL, K_WWD, K_HLT, K_BAD} kind_t;

   typedef struct packed {
      logic          mem_read;
      logic          mem_write;
      logic          i_or_d;
      logic          ir_write;
      logic          pc_write;
      logic [1:0]    pc_src;
      logic          reg_write;
      logic [1:0]    reg_dst;
      logic [1:0]    wb_sel;
      logic          alu_src;
      logic [3:0]    alu_op;
      logic          output_en;
      logic          is_halted;
      logic [CW-1:0] num_inst;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multicycle_control_unit_if #(.WORD_SIZE(WS), .CNT_WIDTH(CW)) bus ();

   multicycle_control_unit #(.WORD_SIZE(WS), .CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   model_count  = 0;
   obs_t exp_q[$];
   obs_t obs_q[$];
   logic rdy_q[$];
   logic tk_q[$];
   int   fn_pool[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 25, 26, 28, 45};
   logic [3:0] r_alu[8] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h9, 4'hC, 4'hD, 4'hA};

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic kind_t kind_of(input logic [15:0] ins);
      logic [3:0] op;
      logic [5:0] fn;
      op = ins[15:12];
      fn = ins[5:0];
      if (op <= 4'd3) return K_BR;
      if (op == 4'd4 || op == 4'd5 || op == 4'd6) return K_IALU;
      if (op == 4'd7) return K_LWD;
      if (op == 4'd8) return K_SWD;
      if (op == 4'd9) return K_JMP;
      if (op == 4'd10) return K_JAL;
      if (op != 4'd15) return K_BAD;
      if (fn <= 6'd7) return K_RALU;
      if (fn == 6'd25) return K_JPR;
      if (fn == 6'd26) return K_JRL;
      if (fn == 6'd28) return K_WWD;
      if (fn == 6'd29) return K_HLT;
      return K_BAD;
   endfunction

   function automatic logic [3:0] alu_of(input logic [15:0] ins);
      logic [3:0] op;
      op = ins[15:12];
      if (op <= 4'd3) return 4'h1;
      if (op == 4'd5) return 4'h6;
      if (op == 4'd6) return 4'hF;
      if (op == 4'd15 && ins[5:0] <= 6'd7) return r_alu[ins[2:0]];
      return 4'h0;
   endfunction

   function automatic obs_t blank();
      obs_t e;
      e          = '0;
      e.num_inst = CW'(model_count);
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = {bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write, bus.pc_src,
           bus.reg_write, bus.reg_dst, bus.wb_sel, bus.alu_src, bus.alu_op, bus.output_en,
           bus.is_halted, bus.num_inst};
      return o;
   endfunction

   task automatic push(input obs_t e, input logic rdy, input logic tk);
      exp_q.push_back(e);
      rdy_q.push_back(rdy);
      tk_q.push_back(tk);
   endtask

   // Builds the expected per-cycle trace of one instruction, then retires it in the model.
   task automatic model_instr(input logic [15:0] ins, input int if_w, input int mem_w, input logic taken);
      kind_t k;
      obs_t  e;
      k = kind_of(ins);
      exp_q.delete();
      rdy_q.delete();
      tk_q.delete();
      for (int i = 0; i <= if_w; i++) begin
         e          = blank();
         e.mem_read = 1'b1;
         if (i == if_w) begin
            e.ir_write = 1'b1;
            e.pc_write = 1'b1;
         end
         push(e, i == if_w, rnd());
      end
      e = blank();
      if (k inside {K_JMP, K_JAL, K_JPR, K_JRL}) begin
         e.pc_write = 1'b1;
         e.pc_src   = (k == K_JMP || k == K_JAL) ? 2'b10 : 2'b11;
         if (k == K_JAL || k == K_JRL) begin
            e.reg_write = 1'b1;
            e.reg_dst   = 2'b10;
            e.wb_sel    = 2'b10;
         end
      end
      if (k == K_WWD) e.output_en = 1'b1;
      push(e, rnd(), rnd());
      if (k inside {K_RALU, K_IALU, K_LWD, K_SWD, K_BR}) begin
         e         = blank();
         e.alu_op  = alu_of(ins);
         e.alu_src = !(k == K_RALU || k == K_BR);
         if (k == K_BR) begin
            e.pc_write = taken;
            e.pc_src   = 2'b01;
         end
         push(e, rnd(), (k == K_BR) ? taken : rnd());
      end
      if (k == K_LWD || k == K_SWD) begin
         for (int i = 0; i <= mem_w; i++) begin
            e           = blank();
            e.i_or_d    = 1'b1;
            e.mem_read  = (k == K_LWD);
            e.mem_write = (k == K_SWD);
            push(e, i == mem_w, rnd());
         end
      end
      if (k inside {K_RALU, K_IALU, K_LWD}) begin
         e           = blank();
         e.reg_write = 1'b1;
         e.reg_dst   = (k == K_RALU) ? 2'b01 : 2'b00;
         e.wb_sel    = (k == K_LWD) ? 2'b01 : 2'b00;
         push(e, rnd(), rnd());
      end
      model_count = (model_count + 1) % (1 << CW);
   endtask

   // Plays the modelled input schedule into the DUT for at most `limit` cycles.
   task automatic exec_trace(input logic [15:0] ins, input int limit);
      obs_q.delete();
      bus.instruction = ins;
      for (int i = 0; i < exp_q.size() && i < limit; i++) begin
         bus.mem_ready    = rdy_q[i];
         bus.branch_taken = tk_q[i];
         @(negedge clk);
         obs_q.push_back(sample());
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      reset       = 1'b0;
      model_count = 0;
   endtask

   task automatic test_reset();
      obs_t o, e;
      reset            = 1'b1;
      bus.mem_ready    = 1'b1;
      bus.branch_taken = 1'b1;
      bus.instruction  = 16'hF000;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         o = sample();
         tests_run++;
         if (o !== '0) begin
            tests_failed++;
            $display("FAIL reset cycle %0d: got %h expected 0", c, o);
         end
         @(posedge clk);
         #1;
      end
      reset         = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      o          = sample();
      e          = '0;
      e.mem_read = 1'b1;
      tests_run++;
      if (o !== e) begin
         tests_failed++;
         $display("FAIL reset_release: got %h expected %h", o, e);
      end
      @(posedge clk);
      #1;
      do_reset(1);
   endtask

   task automatic test_add();
      logic [15:0] ins;
      ins = 16'hF000 | (16'($urandom_range(0, 63)) << 6);
      model_instr(ins, 3, 0, 1'b0);
      tests_run++;
      if (exp_q.size() != 7) begin
         tests_failed++;
         $display("FAIL add_length: got %0d expected 7", exp_q.size());
      end
      exec_trace(ins, 1000);
      for (int i = 0; i < obs_q.size(); i++) begin
         tests_run++;
         if (obs_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL add cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_lwd();
      logic [15:0] ins;
      ins = {4'd7, 12'($urandom)};
      model_instr(ins, $urandom_range(0, 3), 2, 1'b0);
      exec_trace(ins, 1000);
      for (int i = 0; i < obs_q.size(); i++) begin
         tests_run++;
         if (obs_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL lwd cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic [15:0] ins;
      for (int t = 1; t >= 0; t--) begin
         ins = {4'd1, 12'($urandom)};
         model_instr(ins, $urandom_range(0, 2), 0, 1'(t));
         exec_trace(ins, 1000);
         for (int i = 0; i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
               tests_failed++;
               $display("FAIL beq_taken%0d cycle %0d: got %h expected %h", t, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_jal_hlt();
      logic [15:0] ins;
      obs_t        o, e;
      ins = {4'd10, 12'($urandom)};
      model_instr(ins, 1, 0, 1'b0);
      exec_trace(ins, 1000);
      for (int i = 0; i < obs_q.size(); i++) begin
         tests_run++;
         if (obs_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL jal cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      ins = {4'd15, 6'($urandom), 6'd29};
      model_instr(ins, 0, 0, 1'b0);
      exec_trace(ins, 1000);
      for (int i = 0; i < obs_q.size(); i++) begin
         tests_run++;
         if (obs_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL hlt cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      for (int c = 0; c < 6; c++) begin
         bus.instruction  = 16'($urandom);
         bus.mem_ready    = rnd();
         bus.branch_taken = rnd();
         @(negedge clk);
         o           = sample();
         e           = blank();
         e.is_halted = 1'b1;
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL halted cycle %0d: got %h expected %h", c, o, e);
         end
         @(posedge clk);
         #1;
      end
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      o = sample();
      tests_run++;
      if (o !== '0) begin
         tests_failed++;
         $display("FAIL halt_reset: got %h expected 0", o);
      end
      @(posedge clk);
      #1;
      reset       = 1'b0;
      model_count = 0;
   endtask

   task automatic test_random();
      logic [15:0] ins;
      for (int n = 0; n < 40; n++) begin
         ins = {4'($urandom_range(0, 15)), 6'($urandom), 6'(fn_pool[$urandom_range(0, 11)])};
         if ($urandom_range(0, 2) == 0) ins[15:12] = 4'd15;
         model_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), rnd());
         exec_trace(ins, 1000);
         for (int i = 0; i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
               tests_failed++;
               $display("FAIL random n%0d ins %h cycle %0d: got %h expected %h", n, ins, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] ins;
      obs_t        o;
      ins = {4'd7, 12'($urandom)};
      model_instr(ins, 1, 3, 1'b0);
      exec_trace(ins, 6);
      for (int i = 0; i < obs_q.size(); i++) begin
         tests_run++;
         if (obs_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL abort_prefix cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
      reset         = 1'b1;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      o = sample();
      tests_run++;
      if (o !== '0) begin
         tests_failed++;
         $display("FAIL abort_reset: got %h expected 0", o);
      end
      @(posedge clk);
      #1;
      reset       = 1'b0;
      model_count = 0;
      ins = 16'hF001;
      model_instr(ins, 0, 0, 1'b0);
      exec_trace(ins, 1000);
      for (int i = 0; i < obs_q.size(); i++) begin
         tests_run++;
         if (obs_q[i] !== exp_q[i]) begin
            tests_failed++;
            $display("FAIL after_abort cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o, e;
      do_reset(1);
      bus.mem_ready = 1'b0;
      for (int c = 0; c < TMO + 3; c++) begin
         if (c > TMO) bus.mem_ready = 1'b1;
         @(negedge clk);
         o = sample();
         e = blank();
         if (c < TMO) e.mem_read = 1'b1;
         else e.is_halted = 1'b1;
         tests_run++;
         if (o !== e || bus.mem_error !== (c >= TMO)) begin
            tests_failed++;
            $display("FAIL timeout cycle %0d: got %h err %b expected %h err %b", c, o, bus.mem_error, e, c >= TMO);
         end
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.mem_error !== 1'b0 || bus.is_halted !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_reset: got err %b halt %b expected 0 0", bus.mem_error, bus.is_halted);
      end
      @(posedge clk);
      #1;
      reset       = 1'b0;
      model_count = 0;
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset            = 1'b1;
      bus.mem_ready    = 1'b1;
      bus.branch_taken = 1'b0;
      bus.instruction  = '0;
      test_reset();
      test_add();
      test_lwd();
      test_branch();
      test_jal_hlt();
      test_random();
      test_reset_mid();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
